// File: rtl/calc_input_conditioner.sv
// calc_input_conditioner
// Front end of the calculator: synchronizes the raw operand switches,
// operation select and Enter button, debounces Enter, and turns each clean
// press into exactly one NumOut/OpOut command offered under Valid/Ready.
// Reset is asynchronous on assertion; the reset source is expected to
// release it synchronously to clock.
module calc_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic [7:0] NumIn,
  input  logic [1:0] OpIn,
  input  logic       Enter,
  input  logic       Ready,
  output logic [7:0] NumOut,
  output logic [1:0] OpOut,
  output logic       Valid,
  output logic       Overrun
);

  // Debounce counter width is derived from the debounce length.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Width of one synchronized sample: {NumIn, OpIn, Enter}.
  localparam int SW = 11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // With a one-cycle debounce the counting states are bypassed entirely.
  localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_e;

  // Synchronizer chain; stage 0 samples the raw pins, the last stage feeds
  // everything downstream.
  logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
  logic [SYNC_STAGES-1:0][SW-1:0] sync_d;

  logic [7:0] num_s;
  logic [1:0] op_s;
  logic       enter_s;

  // Debounce FSM.
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             capture;

  // Captured command and status.
  logic [7:0] num_q;
  logic [7:0] num_d;
  logic [1:0] op_q;
  logic [1:0] op_d;
  logic       valid_q;
  logic       valid_d;
  logic       ovr_q;
  logic       ovr_d;
  logic       xfer;

  // Shift the raw pins one stage further down the synchronizer each cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], {NumIn, OpIn, Enter}};
  end

  assign num_s   = sync_q[SYNC_STAGES-1][10:3];
  assign op_s    = sync_q[SYNC_STAGES-1][2:1];
  assign enter_s = sync_q[SYNC_STAGES-1][0];

  // Synchronizer flops.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Debounce next-state: a level must hold for DEBOUNCE_CYCLES consecutive
  // samples to be accepted; the counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (enter_s) begin
          if (SINGLE) begin
            state_d = HELD;
            cnt_d   = '0;
            capture = 1'b1;
          end else begin
            state_d = PRESS_DB;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PRESS_DB: begin
        if (!enter_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!enter_s) begin
          if (SINGLE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = RELEASE_DB;
            cnt_d   = CNT_ONE;
          end
        end
      end
      RELEASE_DB: begin
        if (enter_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Debounce state register and counter.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Command register: a capture loads only when the slot is empty or being
  // drained on the same edge; otherwise the new press is dropped and the
  // sticky overrun flag records it.
  always_comb begin
    xfer    = valid_q & Ready;
    num_d   = num_q;
    op_d    = op_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (capture) begin
      if (!valid_q || xfer) begin
        num_d   = num_s;
        op_d    = op_s;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  // Command and status flops.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      num_q   <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      num_q   <= num_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign NumOut  = num_q;
  assign OpOut   = op_q;
  assign Valid   = valid_q;
  assign Overrun = ovr_q;

endmodule

// File: tb/tb_calc_input_conditioner.sv
// Bench for calc_input_conditioner: one instance with a 4-cycle debounce and
// one with a 1-cycle debounce share the operand inputs; each has its own
// Enter/Ready. A run-length reference model predicts accepted presses and
// pushes expected commands into a queue that a negedge monitor drains.
module tb_calc_input_conditioner;

  localparam int S    = 2;
  localparam int HIST = 4096;

  logic       clock = 1'b0;
  logic       Reset;
  logic [7:0] NumIn;
  logic [1:0] OpIn;
  logic       Enter;
  logic       Ready;
  logic       Enter1;
  logic       Ready1;

  logic [7:0] NumOut0;
  logic [7:0] NumOut1;
  logic [1:0] OpOut0;
  logic [1:0] OpOut1;
  logic       Valid0;
  logic       Valid1;
  logic       Overrun0;
  logic       Overrun1;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = 4-cycle debounce, 1 = 1-cycle.
  int         dbc [2] = '{4, 1};
  logic [10:0] raw_hist [2][HIST];
  int         edge_n [2];
  int         run [2];
  bit         db [2];
  bit         m_valid [2];
  bit         m_ovr [2];
  int         pops [2];
  logic [9:0] exp0 [$];
  logic [9:0] exp1 [$];

  calc_input_conditioner #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) u_dut0 (
    .clock(clock),
    .Reset(Reset),
    .NumIn(NumIn),
    .OpIn(OpIn),
    .Enter(Enter),
    .Ready(Ready),
    .NumOut(NumOut0),
    .OpOut(OpOut0),
    .Valid(Valid0),
    .Overrun(Overrun0)
  );

  calc_input_conditioner #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(1)
  ) u_dut1 (
    .clock(clock),
    .Reset(Reset),
    .NumIn(NumIn),
    .OpIn(OpIn),
    .Enter(Enter1),
    .Ready(Ready1),
    .NumOut(NumOut1),
    .OpOut(OpOut1),
    .Valid(Valid1),
    .Overrun(Overrun1)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      edge_n[k]  = 0;
      run[k]     = 0;
      db[k]      = 1'b0;
      m_valid[k] = 1'b0;
      m_ovr[k]   = 1'b0;
    end
    exp0.delete();
    exp1.delete();
  endtask

  // One clock edge of the reference: the design sees raw inputs S edges
  // late; a level is accepted once it has been seen dbc[k] edges in a row.
  task automatic model_step(input int k, input logic [7:0] num, input logic [1:0] op,
                            input logic ent, input logic rdy);
    logic [10:0] seen;
    bit cap;
    bit xfer;
    raw_hist[k][edge_n[k] % HIST] = {num, op, ent};
    seen = (edge_n[k] >= S) ? raw_hist[k][(edge_n[k] - S) % HIST] : 11'd0;
    cap = 1'b0;
    if (seen[0] != db[k]) begin
      run[k] = run[k] + 1;
      if (run[k] == dbc[k]) begin
        db[k]  = seen[0];
        run[k] = 0;
        cap    = seen[0];
      end
    end else begin
      run[k] = 0;
    end
    xfer = m_valid[k] && (rdy == 1'b1);
    if (cap) begin
      if (!m_valid[k] || xfer) begin
        m_valid[k] = 1'b1;
        if (k == 0) exp0.push_back(seen[10:1]);
        else        exp1.push_back(seen[10:1]);
      end else begin
        m_ovr[k] = 1'b1;
      end
    end else if (xfer) begin
      m_valid[k] = 1'b0;
    end
    edge_n[k]++;
  endtask

  task automatic monitor_one(input int k);
    logic       v;
    logic       o;
    logic       r;
    logic [9:0] act;
    logic [9:0] front;
    bit         have;
    if (k == 0) begin
      v = Valid0; o = Overrun0; r = Ready;  act = {NumOut0, OpOut0};
      have = (exp0.size() > 0);
    end else begin
      v = Valid1; o = Overrun1; r = Ready1; act = {NumOut1, OpOut1};
      have = (exp1.size() > 0);
    end
    check((k == 0) ? "valid0" : "valid1", 32'(v), 32'(m_valid[k]));
    check((k == 0) ? "overrun0" : "overrun1", 32'(o), 32'(m_ovr[k]));
    if (v === 1'b1) begin
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL command%0d actual=%0h required=none_pending", k, act);
      end else begin
        front = (k == 0) ? exp0[0] : exp1[0];
        if (act !== front) begin
          errors++;
          $display("FAIL command%0d actual=%0h required=%0h", k, act, front);
        end
        if (r === 1'b1) begin
          if (k == 0) void'(exp0.pop_front());
          else        void'(exp1.pop_front());
          pops[k]++;
        end
      end
    end
  endtask

  // Reference model advances on every edge the design is out of reset.
  initial begin
    forever begin
      @(posedge clock);
      if (Reset === 1'b1) begin
        model_step(0, NumIn, OpIn, Enter, Ready);
        model_step(1, NumIn, OpIn, Enter1, Ready1);
      end
    end
  end

  // Monitor: compares outputs between edges and drains the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      monitor_one(0);
      monitor_one(1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b0;
    reset_model();
    #1;
    check("rst_num0", 32'(NumOut0), 32'h00);
    check("rst_op0", 32'(OpOut0), 32'h0);
    check("rst_valid0", 32'(Valid0), 32'h0);
    check("rst_ovr0", 32'(Overrun0), 32'h0);
    check("rst_valid1", 32'(Valid1), 32'h0);
    @(posedge clock);
    #3 Reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int len;
    int base;
    pops[0] = 0;
    pops[1] = 0;
    Reset = 1'b1; NumIn = '0; OpIn = '0; Enter = 1'b0; Ready = 1'b0;
    Enter1 = 1'b0; Ready1 = 1'b0;
    #2 apply_reset();

    // Clean press, exact latency, handshake, no recapture while held.
    NumIn = 8'h2A; OpIn = 2'b01; Ready = 1'b0; Enter = 1'b1;
    tick(5);
    check("latency_early", 32'(Valid0), 32'h0);
    tick(1);
    check("latency_valid", 32'(Valid0), 32'h1);
    check("clean_num", 32'(NumOut0), 32'h2A);
    check("clean_op", 32'(OpOut0), 32'h1);
    tick(14);
    Ready = 1'b1; tick(1); Ready = 1'b0;
    check("xfer_drop", 32'(Valid0), 32'h0);
    tick(5);
    check("no_recapture", 32'(Valid0), 32'h0);
    Enter = 1'b0; tick(10);

    // Bounce reject.
    Enter = 1'b1; tick(3); Enter = 1'b0; tick(1); Enter = 1'b1; tick(3);
    Enter = 1'b0; tick(10);
    check("bounce_reject", 32'(Valid0), 32'h0);

    // Release bounce after a capture.
    NumIn = 8'h5C; OpIn = 2'b10; Enter = 1'b1; tick(6);
    check("rb_valid", 32'(Valid0), 32'h1);
    check("rb_num", 32'(NumOut0), 32'h5C);
    Enter = 1'b0; tick(2); Enter = 1'b1; tick(11);
    check("rb_overrun", 32'(Overrun0), 32'h0);
    check("rb_hold_num", 32'(NumOut0), 32'h5C);
    Enter = 1'b0; tick(10);

    // Overrun: second press while the first is still pending.
    NumIn = 8'h77; OpIn = 2'b11; Enter = 1'b1; tick(10);
    check("ovr_keep_num", 32'(NumOut0), 32'h5C);
    check("ovr_keep_op", 32'(OpOut0), 32'h2);
    check("ovr_flag", 32'(Overrun0), 32'h1);
    Enter = 1'b0; tick(10);

    // Transfer and capture on the same edge.
    NumIn = 8'h77; OpIn = 2'b00; Enter = 1'b1; tick(5);
    Ready = 1'b1; tick(1); Ready = 1'b0;
    check("coinc_valid", 32'(Valid0), 32'h1);
    check("coinc_num", 32'(NumOut0), 32'h77);
    check("coinc_op", 32'(OpOut0), 32'h0);
    check("coinc_ovr", 32'(Overrun0), 32'h1);
    Enter = 1'b0; tick(10);

    // Asynchronous reset mid-cycle with a pending command and overrun set.
    check("pre_rst_valid", 32'(Valid0), 32'h1);
    check("pre_rst_ovr", 32'(Overrun0), 32'h1);
    #2 apply_reset();
    NumIn = 8'h3C; OpIn = 2'b10; Enter = 1'b1; tick(5);
    check("post_rst_early", 32'(Valid0), 32'h0);
    tick(1);
    check("post_rst_valid", 32'(Valid0), 32'h1);
    check("post_rst_num", 32'(NumOut0), 32'h3C);
    Ready = 1'b1; tick(1); Ready = 1'b0;
    Enter = 1'b0; tick(10);

    // Randomized Enter run lengths, operands and Ready.
    for (int i = 0; i < 60; i++) begin
      len = $urandom_range(1, 8);
      Enter = ~Enter;
      for (int j = 0; j < len; j++) begin
        NumIn = 8'($urandom);
        OpIn  = 2'($urandom);
        Ready = ($urandom_range(0, 3) != 0);
        tick(1);
      end
    end
    Enter = 1'b0; Ready = 1'b1; tick(20); Ready = 1'b0;

    // One-cycle debounce instance.
    NumIn = 8'hA5; OpIn = 2'b11; Enter1 = 1'b1;
    tick(2);
    check("d1_early", 32'(Valid1), 32'h0);
    tick(1);
    check("d1_valid", 32'(Valid1), 32'h1);
    check("d1_num", 32'(NumOut1), 32'hA5);
    check("d1_op", 32'(OpOut1), 32'h3);
    Enter1 = 1'b0; Ready1 = 1'b1; tick(3);
    check("d1_drop", 32'(Valid1), 32'h0);
    base = pops[1];
    for (int i = 0; i < 10; i++) begin
      NumIn = 8'($urandom);
      OpIn  = 2'($urandom);
      Enter1 = 1'b1; tick(1);
      Enter1 = 1'b0; tick(1);
    end
    tick(6);
    check("d1_one_per_press", 32'(pops[1] - base), 32'd10);
    check("d1_overrun", 32'(Overrun1), 32'h0);

    Ready = 1'b1; Ready1 = 1'b1; tick(5);
    check("drained0", 32'(exp0.size()), 32'd0);
    check("drained1", 32'(exp1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
